// File: rtl/tiny_rv_csr_file.sv
// Machine-mode CSR file for tiny_rv32: single-cycle read-modify-write responder,
// trap entry / mret state, and the 64-bit cycle and retired-instruction counters.
module tiny_rv_csr_file #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        req_valid,
  input  logic [11:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_wdata,
  input  logic        req_wen,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        instret_inc,
  input  logic        irq_ext,
  output logic [31:0] o_trap_vector,
  output logic [31:0] o_epc,
  output logic        o_mie_global
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Architectural state
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_bits;
  logic [31:0] mtvec_base;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Request-stage decode
  logic [31:0] old_p0;
  logic        hit_p0;
  logic        wr_try_p0;
  logic        illegal_p0;
  logic        wr_go_p0;
  logic [31:0] new_p0;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic wr_cyc_lo, wr_cyc_hi, wr_ret_lo, wr_ret_hi;

  function automatic logic [31:0] rmw(input logic [1:0] op, input logic [31:0] old,
                                      input logic [31:0] wdata);
    case (op)
      OP_RW:   rmw = wdata;
      OP_RS:   rmw = old | wdata;
      OP_RC:   rmw = old & ~wdata;
      default: rmw = old;
    endcase
  endfunction

  // MPP is hardwired to machine mode, so it always reads back as 2'b11.
  function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
    mstatus_view = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
  endfunction

  always_comb begin
    old_p0 = 32'd0;
    hit_p0 = 1'b1;
    case (req_addr)
      A_MSTATUS:              old_p0 = mstatus_view(mstatus_mie, mstatus_mpie);
      A_MISA:                 old_p0 = MISA_VAL;
      A_MIE:                  old_p0 = mie_bits;
      A_MTVEC:                old_p0 = mtvec_base;
      A_MSCRATCH:             old_p0 = mscratch;
      A_MEPC:                 old_p0 = mepc;
      A_MCAUSE:               old_p0 = mcause;
      A_MTVAL:                old_p0 = mtval;
      A_MIP:                  old_p0 = {20'd0, irq_ext, 11'd0};
      A_MCYCLE, A_CYCLE:      old_p0 = mcycle[31:0];
      A_MCYCLEH, A_CYCLEH:    old_p0 = mcycle[63:32];
      A_MINSTRET, A_INSTRET:  old_p0 = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: old_p0 = minstret[63:32];
      A_MHARTID:              old_p0 = HART_ID;
      default:                hit_p0 = 1'b0;
    endcase
  end

  // Writes to the read-only 0xC00-0xFFF window are illegal only when they would take effect.
  always_comb begin
    wr_try_p0  = (req_op != OP_READ) && req_wen;
    illegal_p0 = !hit_p0 || ((req_addr[11:10] == 2'b11) && wr_try_p0);
    wr_go_p0   = req_valid && wr_try_p0 && !illegal_p0;
    new_p0     = rmw(req_op, old_p0, req_wdata);
  end

  always_comb begin
    wr_mstatus  = wr_go_p0 && (req_addr == A_MSTATUS) && !trap_valid && !mret_valid;
    wr_mie      = wr_go_p0 && (req_addr == A_MIE);
    wr_mtvec    = wr_go_p0 && (req_addr == A_MTVEC);
    wr_mscratch = wr_go_p0 && (req_addr == A_MSCRATCH);
    wr_mepc     = wr_go_p0 && (req_addr == A_MEPC)   && !trap_valid;
    wr_mcause   = wr_go_p0 && (req_addr == A_MCAUSE) && !trap_valid;
    wr_mtval    = wr_go_p0 && (req_addr == A_MTVAL)  && !trap_valid;
    wr_cyc_lo   = wr_go_p0 && (req_addr == A_MCYCLE);
    wr_cyc_hi   = wr_go_p0 && (req_addr == A_MCYCLEH);
    wr_ret_lo   = wr_go_p0 && (req_addr == A_MINSTRET);
    wr_ret_hi   = wr_go_p0 && (req_addr == A_MINSTRETH);
  end

  // ---- p0 -> p1: response register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_illegal <= 1'b0;
    end else begin
      resp_valid <= req_valid;
      if (req_valid) begin
        resp_rdata   <= illegal_p0 ? 32'd0 : old_p0;
        resp_illegal <= illegal_p0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_valid) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_mstatus) begin
      mstatus_mie  <= new_p0[3];
      mstatus_mpie <= new_p0[7];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mie_bits   <= 32'd0;
      mtvec_base <= 32'd0;
      mscratch   <= 32'd0;
    end else begin
      if (wr_mie)      mie_bits   <= new_p0 & MIE_MASK;
      if (wr_mtvec)    mtvec_base <= new_p0 & ALIGN_MASK;
      if (wr_mscratch) mscratch   <= new_p0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mepc   <= 32'd0;
      mcause <= 32'd0;
      mtval  <= 32'd0;
    end else if (trap_valid) begin
      mepc   <= trap_pc & ALIGN_MASK;
      mcause <= trap_cause;
      mtval  <= trap_tval;
    end else begin
      if (wr_mepc)   mepc   <= new_p0 & ALIGN_MASK;
      if (wr_mcause) mcause <= new_p0;
      if (wr_mtval)  mtval  <= new_p0;
    end
  end

  // A software write to either half suppresses that counter's increment for the cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mcycle <= 64'd0;
    end else if (wr_cyc_lo) begin
      mcycle[31:0] <= new_p0;
    end else if (wr_cyc_hi) begin
      mcycle[63:32] <= new_p0;
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      minstret <= 64'd0;
    end else if (wr_ret_lo) begin
      minstret[31:0] <= new_p0;
    end else if (wr_ret_hi) begin
      minstret[63:32] <= new_p0;
    end else if (instret_inc) begin
      minstret <= minstret + 64'd1;
    end
  end

  assign o_trap_vector = mtvec_base;
  assign o_epc         = mepc;
  assign o_mie_global  = mstatus_mie;

endmodule

// File: tb/tb_tiny_rv_csr_file.sv
// Scoreboard bench for tiny_rv_csr_file: a spec-level CSR model predicts every
// response at the sampling edge; an independent monitor compares at the next negedge.
module tb_tiny_rv_csr_file;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        req_valid;
  logic [11:0] req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        req_wen;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        instret_inc;
  logic        irq_ext;
  logic [31:0] o_trap_vector;
  logic [31:0] o_epc;
  logic        o_mie_global;

  tiny_rv_csr_file dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op),
    .req_wdata(req_wdata), .req_wen(req_wen),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_valid(mret_valid), .instret_inc(instret_inc),
    .irq_ext(irq_ext), .o_trap_vector(o_trap_vector), .o_epc(o_epc),
    .o_mie_global(o_mie_global)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Reference model state (architectural view)
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  logic [63:0] m_cyc, m_ret;

  logic [11:0] addrs [0:22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                                12'h7C0, 12'h345, 12'hF11, 12'h000, 12'h306};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_ie = 0; m_tvec = 0; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
    m_cyc = 0; m_ret = 0;
    q.delete();
  endtask

  function automatic logic m_read(input logic [11:0] a, output logic [31:0] v);
    v = 32'd0;
    m_read = 1'b1;
    case (a)
      12'h300: v = 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_ie;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
      12'h344: v = irq_ext ? 32'h800 : 32'h0;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ret[31:0];
      12'hB82, 12'hC82: v = m_ret[63:32];
      12'hF14: v = 32'd0;
      default: m_read = 1'b0;
    endcase
  endfunction

  // Applies one clock edge's worth of architectural behaviour to the model.
  task automatic model_step();
    logic [31:0] old, nv;
    logic        impl, wr, ill, old_mie, old_mpie;
    logic [63:0] ncyc, nret;
    exp_t        e;
    cyc++;
    if (!i_rst_n) return;
    ncyc = m_cyc + 64'd1;
    nret = instret_inc ? m_ret + 64'd1 : m_ret;
    old_mie = m_mie;
    old_mpie = m_mpie;
    if (req_valid) begin
      impl = m_read(req_addr, old);
      wr = (req_op != 2'b00) && req_wen;
      ill = !impl || ((req_addr[11:10] == 2'b11) && wr);
      e.rdata = ill ? 32'd0 : old;
      e.ill = ill;
      e.due = cyc;
      q.push_back(e);
      if (wr && !ill) begin
        if (req_op == 2'b01) nv = req_wdata;
        else if (req_op == 2'b10) nv = old | req_wdata;
        else nv = old & ~req_wdata;
        case (req_addr)
          12'h300: if (!trap_valid && !mret_valid) begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_ie = nv & 32'h888;
          12'h305: m_tvec = {nv[31:2], 2'b00};
          12'h340: m_scratch = nv;
          12'h341: if (!trap_valid) m_epc = {nv[31:2], 2'b00};
          12'h342: if (!trap_valid) m_cause = nv;
          12'h343: if (!trap_valid) m_tval = nv;
          12'hB00: ncyc = {m_cyc[63:32], nv};
          12'hB80: ncyc = {nv, m_cyc[31:0]};
          12'hB02: nret = {m_ret[63:32], nv};
          12'hB82: nret = {nv, m_ret[31:0]};
          default: ;
        endcase
      end
    end
    m_cyc = ncyc;
    m_ret = nret;
    if (trap_valid) begin
      m_epc = {trap_pc[31:2], 2'b00};
      m_cause = trap_cause;
      m_tval = trap_tval;
      m_mpie = old_mie;
      m_mie = 1'b0;
    end else if (mret_valid) begin
      m_mie = old_mpie;
      m_mpie = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = 12'h0; req_op = 2'b00; req_wdata = 32'h0; req_wen = 1'b0;
    trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
    mret_valid = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                     input logic w);
    req_valid = 1'b1; req_addr = a; req_op = op; req_wdata = d; req_wen = w;
    step();
    idle_inputs();
  endtask

  // Monitor: pops one expectation per observed response strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          e = q.pop_front();
          chk("resp_missing", 32'(resp_valid), 32'd1);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("resp_valid", 32'(resp_valid), 32'd1);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_illegal", 32'(resp_illegal), 32'(e.ill));
        end else if (resp_valid) begin
          chk("resp_valid_unexpected", 32'(resp_valid), 32'd0);
        end
        chk("o_trap_vector", o_trap_vector, m_tvec);
        chk("o_epc", o_epc, m_epc);
        chk("o_mie_global", 32'(o_mie_global), 32'(m_mie));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    irq_ext = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) step();
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_o_trap_vector", o_trap_vector, 32'd0);
    chk("reset_o_epc", o_epc, 32'd0);
    chk("reset_o_mie_global", 32'(o_mie_global), 32'd0);
    i_rst_n = 1'b1;
    step();

    // Read-modify-write on mscratch
    csr(12'h340, 2'b01, 32'hDEADBEEF, 1'b1);
    chk("t1_rw_old", resp_rdata, 32'h0);
    csr(12'h340, 2'b10, 32'h10, 1'b1);
    chk("t1_rs_old", resp_rdata, 32'hDEADBEEF);
    csr(12'h340, 2'b00, 32'h0, 1'b0);
    chk("t1_mscratch", resp_rdata, 32'hDEADBEFF);

    // mtvec alignment
    csr(12'h305, 2'b01, 32'h8000_0003, 1'b1);
    chk("t2_vector", o_trap_vector, 32'h8000_0000);
    csr(12'h305, 2'b00, 32'h0, 1'b0);
    chk("t2_mtvec_read", resp_rdata, 32'h8000_0000);

    // Trap entry and mret
    csr(12'h300, 2'b10, 32'h8, 1'b1);
    trap_valid = 1'b1; trap_pc = 32'h104; trap_cause = 32'h2; trap_tval = 32'h13;
    step();
    idle_inputs();
    chk("t3_epc", o_epc, 32'h104);
    csr(12'h342, 2'b00, 32'h0, 1'b0);
    chk("t3_mcause", resp_rdata, 32'h2);
    csr(12'h343, 2'b00, 32'h0, 1'b0);
    chk("t3_mtval", resp_rdata, 32'h13);
    csr(12'h300, 2'b00, 32'h0, 1'b0);
    chk("t3_mstatus_trap", resp_rdata, 32'h1880);
    mret_valid = 1'b1;
    step();
    idle_inputs();
    csr(12'h300, 2'b00, 32'h0, 1'b0);
    chk("t3_mstatus_mret", resp_rdata, 32'h1888);

    // Read-only window and unimplemented address
    csr(12'hC00, 2'b01, 32'h1234, 1'b1);
    chk("t4_ro_write_illegal", 32'(resp_illegal), 32'd1);
    chk("t4_ro_write_rdata", resp_rdata, 32'd0);
    csr(12'hC00, 2'b10, 32'h0, 1'b0);
    chk("t4_ro_probe_legal", 32'(resp_illegal), 32'd0);
    csr(12'h7C0, 2'b00, 32'h0, 1'b0);
    chk("t4_unimpl_illegal", 32'(resp_illegal), 32'd1);

    // Counter wrap and instret
    csr(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b1);
    csr(12'hB80, 2'b01, 32'hFFFF_FFFF, 1'b1);
    step();
    csr(12'hB80, 2'b00, 32'h0, 1'b0);
    chk("t5_mcycleh_wrap", resp_rdata, 32'h0);
    csr(12'hB00, 2'b00, 32'h0, 1'b0);
    chk("t5_mcycle_wrap", resp_rdata, 32'h1);
    csr(12'hB02, 2'b01, 32'h0, 1'b1);
    csr(12'hB82, 2'b01, 32'h0, 1'b1);
    repeat (3) begin
      instret_inc = 1'b1;
      step();
      instret_inc = 1'b0;
      step();
    end
    csr(12'hB02, 2'b00, 32'h0, 1'b0);
    chk("t5_minstret", resp_rdata, 32'h3);

    // Same-cycle interactions with a trap
    csr(12'h304, 2'b01, 32'hFFFF_FFFF, 1'b1);
    trap_valid = 1'b1; trap_pc = 32'h300; trap_cause = 32'h7; trap_tval = 32'h0;
    instret_inc = 1'b1;
    csr(12'h304, 2'b11, 32'h8, 1'b1);
    chk("t6_rc_old", resp_rdata, 32'h888);
    csr(12'h304, 2'b00, 32'h0, 1'b0);
    chk("t6_mie_after_rc", resp_rdata, 32'h880);
    trap_valid = 1'b1; trap_pc = 32'h202; trap_cause = 32'h3; trap_tval = 32'h55;
    csr(12'h341, 2'b01, 32'h5550, 1'b1);
    chk("t6_mepc_trap_wins", o_epc, 32'h200);

    // Reset while a response is pending
    req_valid = 1'b1; req_addr = 12'h340; req_op = 2'b01; req_wdata = 32'h1234; req_wen = 1'b1;
    @(posedge i_clk);
    model_step();
    #2;
    i_rst_n = 1'b0;
    model_reset();
    @(negedge i_clk);
    idle_inputs();
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_rdata", resp_rdata, 32'd0);
    chk("rst_mid_vector", o_trap_vector, 32'd0);
    chk("rst_mid_epc", o_epc, 32'd0);
    chk("rst_mid_mie", 32'(o_mie_global), 32'd0);
    repeat (2) step();
    i_rst_n = 1'b1;
    csr(12'h340, 2'b00, 32'h0, 1'b0);
    chk("rst_mscratch", resp_rdata, 32'd0);
    csr(12'h300, 2'b00, 32'h0, 1'b0);
    chk("rst_mstatus", resp_rdata, 32'h1800);
    csr(12'h304, 2'b00, 32'h0, 1'b0);
    csr(12'h342, 2'b00, 32'h0, 1'b0);
    csr(12'hB82, 2'b00, 32'h0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_addr    = addrs[$urandom_range(0, 22)];
      req_op      = 2'($urandom_range(0, 3));
      req_wdata   = $urandom;
      req_wen     = ($urandom_range(0, 4) != 0);
      trap_valid  = ($urandom_range(0, 15) == 0);
      trap_cause  = $urandom;
      trap_pc     = $urandom;
      trap_tval   = $urandom;
      mret_valid  = ($urandom_range(0, 11) == 0);
      instret_inc = ($urandom_range(0, 1) == 1);
      irq_ext     = ($urandom_range(0, 1) == 1);
      step();
    end
    idle_inputs();
    repeat (2) step();
    if (q.size() != 0) chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tiny_rv_csr_file.md
Name: tiny_rv_csr_file

Overview:
Machine-mode CSR register file for the tiny_rv32 core. It is the responder side of the CSR access path. The execute-stage CSR unit issues read-modify-write requests (CSRRW/CSRRS/CSRRC and immediate forms, already resolved to a write value) and gets back the old CSR value one cycle later. The block also owns trap entry, mret state restore, and the cycle and retired-instruction counters.

Parameters:
HART_ID, 0, value returned by mhartid (0xF14)
MISA_VAL, 32'h4000_0100, value returned by misa (0x301), RV32I

Ports:
i_clk  input  1  core clock
i_rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CSR access request, single-cycle pulse
req_addr  input  12  CSR address
req_op  input  2  01=RW, 10=RS (set), 11=RC (clear), 00=read-only probe
req_wdata  input  32  rs1 value or zero-extended uimm
req_wen  input  1  write enabled; 0 when rs1/uimm is x0 for RS/RC
resp_valid  output  1  response strobe, one cycle after req_valid
resp_rdata  output  32  old CSR value
resp_illegal  output  1  access is illegal; valid with resp_valid
trap_valid  input  1  take trap this cycle
trap_cause  input  32  mcause value
trap_pc  input  32  faulting pc
trap_tval  input  32  mtval value
mret_valid  input  1  execute mret this cycle
instret_inc  input  1  one instruction retired this cycle
irq_ext  input  1  external interrupt level, reflected in mip.MEIP
o_trap_vector  output  32  mtvec base (mtvec & ~3)
o_epc  output  32  current mepc
o_mie_global  output  1  mstatus.MIE

Behaviour:
- Reset (async, on i_rst_n low) clears resp_valid, resp_rdata, resp_illegal, mstatus.MIE, mstatus.MPIE, mie, mtvec, mscratch, mepc, mcause, mtval, mcycle, and minstret to 0. o_* outputs follow the registers.
- Always ready; there is no backpressure. Request sampled at edge N gives resp_valid=1 for exactly the cycle after edge N. If there is no request, resp_valid is 0 and resp_rdata holds its previous value.
- Write value by op:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - op=00, or req_wen=0: no write.
  - The write commits at the same edge that captures resp_rdata = old.
- Implemented CSRs:
  - mstatus 0x300: MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: reads MISA_VAL; writes ignored (legal).
  - mie 0x304: bits 3, 7, 11 writable; others read 0.
  - mtvec 0x305: direct mode only; bits[1:0] read 0.
  - mscratch 0x340: full 32 bits writable.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342, mtval 0x343: full 32 bits writable.
  - mip 0x344: read-only, bit11 = irq_ext; writes ignored (legal).
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: read/write halves of two 64-bit counters.
  - cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82: read-only shadows of the counters.
  - mhartid 0xF14: reads HART_ID.
- Illegal access gives resp_illegal=1, resp_rdata=0, and no state change. Illegal when:
  - the address is unimplemented, or
  - addr[11:10]==2'b11 and a write is effective (op!=00 and req_wen=1).
- Counters:
  - mcycle increments every cycle after reset.
  - minstret increments when instret_inc=1.
  - Both are 64-bit and wrap from all-ones to 0.
  - A CSR write to either half in the same cycle takes priority over the increment for the whole counter that cycle; the other half holds its value.
- Trap entry (trap_valid=1):
  - mepc <= trap_pc & ~3, mcause <= trap_cause, mtval <= trap_tval.
  - MPIE <= MIE, MIE <= 0.
- mret (mret_valid=1): MIE <= MPIE, MPIE <= 1.
- Priority within one cycle: trap > mret > CSR write for any register they share. A same-cycle CSR request to a trap-affected register still responds with the pre-edge old value, but its write is dropped. Writes to other registers proceed normally.
- Reset mid-operation: any pending response is discarded; resp_valid is 0 after reset.

Test Plan:
1. Reset, then RW 0x340 wdata=0xDEADBEEF; next cycle RS 0x340 wdata=0x10 -> first resp_rdata=0, second resp_rdata=0xDEADBEEF; mscratch becomes 0xDEADBEFF.
2. RW 0x305 wdata=0x8000_0003 -> o_trap_vector=0x8000_0000; a subsequent read returns 0x8000_0000.
3. Set MIE (RS 0x300 wdata=0x8), then trap_valid with pc=0x104, cause=0x2, tval=0x13 -> mepc=0x104, mcause=2, mtval=0x13, mstatus reads 0x1880. Then mret_valid -> mstatus reads 0x1888.
4. RW 0xC00 with req_wen=1 -> resp_illegal=1, rdata=0. RS 0xC00 with req_wen=0 -> legal, returns the cycle count. Read 0x7C0 -> illegal.
5. RW 0xB00 wdata=0xFFFF_FFFF and 0xB80 wdata=0xFFFF_FFFF, then idle 2 cycles -> mcycleh=0, mcycle=1. Pulse instret_inc 3 times -> minstret=3.
6. RC 0x304 and instret_inc in the same cycle as trap_valid; RW 0x341 in the same cycle as trap_valid -> the mepc write is dropped and mepc=trap_pc. Assert i_rst_n low mid-request -> resp_valid=0 and all registers are 0.
